// File: rtl/gate_chk_pkg.sv
// Shared types and bit positions for the gate checker.
// Covers the FSM state encoding, the vector count and the ui_in/uo_out field layout.
package gate_chk_pkg;

    localparam int unsigned NUM_VECTORS = 4;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCompare,
        StDone
    } state_e;

    // uo_out field positions
    localparam int unsigned UoBusy     = 0;
    localparam int unsigned UoDone     = 1;
    localparam int unsigned UoPass     = 2;
    localparam int unsigned UoFail     = 3;
    localparam int unsigned UoFirstLsb = 4;
    localparam int unsigned UoCountLsb = 6;

    // ui_in gate result positions
    localparam int unsigned UiAnd  = 0;
    localparam int unsigned UiOr   = 1;
    localparam int unsigned UiXor  = 2;
    localparam int unsigned UiNand = 3;
    localparam int unsigned UiNor  = 4;
    localparam int unsigned UiXnor = 5;
    localparam int unsigned UiNotA = 6;
    localparam int unsigned UiB    = 7;

    function automatic logic [1:0] sat_inc2(input logic [1:0] x);
        return (x == 2'd3) ? x : x + 2'd1;
    endfunction

endpackage

// File: rtl/gate_chk_golden.sv
// Golden gate model: the result byte a correct device under test returns for inputs (a, b).
// Purely combinational.
module gate_golden
    import gate_chk_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [7:0] exp_o
);

    always_comb begin
        exp_o         = '0;
        exp_o[UiAnd]  = a_i & b_i;
        exp_o[UiOr]   = a_i | b_i;
        exp_o[UiXor]  = a_i ^ b_i;
        exp_o[UiNand] = ~(a_i & b_i);
        exp_o[UiNor]  = ~(a_i | b_i);
        exp_o[UiXnor] = ~(a_i ^ b_i);
        exp_o[UiNotA] = ~a_i;
        exp_o[UiB]    = b_i;
    end

endmodule

// File: rtl/tt_um_gate_checker.sv
// Gate checker: steps the four (A,B) vectors, waits for the device to settle and compares the
// returned gate results against a golden model, reporting pass/fail, first failure and count.
module tt_um_gate_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES);
    localparam logic [1:0] LastVec    = 2'(NUM_VECTORS - 1);

    state_e state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [1:0] drive_vec_q, drive_vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] fail_cnt_q, fail_cnt_d;
    logic [1:0] first_idx_q, first_idx_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_valid_q;
    logic start_prev_q;
    logic start_sync;
    logic start_edge;
    logic [7:0] golden;
    logic mismatch;
    logic unused_uio;

    assign unused_uio = ^uio_in[7:1];

    // sync_valid_q tracks pipeline fill after reset so a start held high through reset is seen
    // as a level, not an edge; start_prev_q resets high for the same reason.
    assign start_sync = sync_q[SYNC_STAGES-1];
    assign start_edge = sync_valid_q[SYNC_STAGES-1] & start_sync & ~start_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            sync_valid_q <= '0;
            start_prev_q <= 1'b1;
        end else if (ena) begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], uio_in[0]};
            sync_valid_q <= {sync_valid_q[SYNC_STAGES-2:0], 1'b1};
            start_prev_q <= sync_valid_q[SYNC_STAGES-1] ? start_sync : 1'b1;
        end
    end

    gate_golden u_golden (
        .a_i   (drive_vec_q[1]),
        .b_i   (drive_vec_q[0]),
        .exp_o (golden)
    );

    assign mismatch = (ui_in != golden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q       <= '0;
            drive_vec_q <= '0;
            cnt_q       <= '0;
            fail_cnt_q  <= '0;
            first_idx_q <= '0;
        end else if (ena) begin
            vec_q       <= vec_d;
            drive_vec_q <= drive_vec_d;
            cnt_q       <= cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            first_idx_q <= first_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        drive_vec_d = drive_vec_q;
        cnt_d       = cnt_q;
        fail_cnt_d  = fail_cnt_q;
        first_idx_d = first_idx_q;
        case (state_q)
            StIdle, StDone: begin
                if (start_edge) begin
                    state_d     = StDrive;
                    vec_d       = '0;
                    drive_vec_d = '0;
                    fail_cnt_d  = '0;
                    first_idx_d = '0;
                end
            end
            StDrive: begin
                state_d = StSettle;
                cnt_d   = SettleLoad;
            end
            StSettle: begin
                if (cnt_q <= 8'd1) begin
                    state_d = StCompare;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StCompare: begin
                if (mismatch) begin
                    if (fail_cnt_q == 2'd0) begin
                        first_idx_d = vec_q;
                    end
                    fail_cnt_d = sat_inc2(fail_cnt_q);
                end
                if (vec_q == LastVec) begin
                    state_d = StDone;
                end else begin
                    state_d     = StDrive;
                    vec_d       = vec_q + 2'd1;
                    drive_vec_d = vec_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result fields are only exposed in DONE so an aborted or running pass shows nothing partial.
    always_comb begin
        uo_out = '0;
        case (state_q)
            StDrive, StSettle, StCompare: uo_out[UoBusy] = 1'b1;
            StDone: begin
                uo_out[UoDone]            = 1'b1;
                uo_out[UoPass]            = (fail_cnt_q == 2'd0);
                uo_out[UoFail]            = (fail_cnt_q != 2'd0);
                uo_out[UoFirstLsb +: 2]   = first_idx_q;
                uo_out[UoCountLsb +: 2]   = fail_cnt_q;
            end
            default: uo_out = '0;
        endcase
    end

    // uio_out bit0 carries A (vector MSB), bit1 carries B (vector LSB).
    assign uio_out = {6'b0, drive_vec_q[0], drive_vec_q[1]};
    assign uio_oe  = 8'b0000_0011;

endmodule

// File: tb/tb_tt_um_gate_checker.sv
// Self-checking bench for tt_um_gate_checker: a behavioural gate device with injectable faults,
// and a scoreboard of expected result bytes and run latencies.
module tb_tt_um_gate_checker;

    localparam int Settle = 4;
    localparam int Sync   = 2;
    localparam int Pause  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;
    int         mode;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         lat_q[$];

    always #5 clk = ~clk;

    tt_um_gate_checker #(
        .SETTLE_CYCLES (Settle),
        .SYNC_STAGES   (Sync)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    function automatic logic [7:0] ideal(input logic a, input logic b);
        logic [7:0] r;
        r[0] = a & b;
        r[1] = a | b;
        r[2] = a ^ b;
        r[3] = !(a && b);
        r[4] = !(a || b);
        r[5] = (a == b);
        r[6] = !a;
        r[7] = b;
        return r;
    endfunction

    // mode 0: ideal device, 1: XOR output stuck at 0, 2: all outputs stuck at 0
    function automatic logic [7:0] dev(input logic a, input logic b, input int m);
        logic [7:0] r;
        r = ideal(a, b);
        if (m == 1) r[2] = 1'b0;
        if (m == 2) r = 8'h00;
        return r;
    endfunction

    function automatic logic [7:0] expected_uo(input int m);
        int fails;
        logic [1:0] first;
        logic [1:0] vv;
        logic [7:0] r;
        fails = 0;
        first = 2'd0;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (dev(vv[1], vv[0], m) != ideal(vv[1], vv[0])) begin
                if (fails == 0) first = vv;
                fails++;
            end
        end
        r      = 8'h00;
        r[1]   = 1'b1;
        r[2]   = (fails == 0);
        r[3]   = (fails != 0);
        r[5:4] = first;
        r[7:6] = (fails > 3) ? 2'd3 : 2'(fails);
        return r;
    endfunction

    always_comb ui_in = dev(uio_out[0], uio_out[1], mode);

    task automatic run_check(input string name, input int m, input int pause_at,
                             input int retrig_at);
        int cycles;
        logic [7:0] exp_b;
        int exp_l;
        mode = m;
        exp_q.push_back(expected_uo(m));
        lat_q.push_back(Sync + 1 + 4 * (Settle + 2) + ((pause_at > 0) ? Pause : 0));
        @(negedge clk);
        uio_in[0] = 1'b1;
        cycles = 0;
        while (!(cycles > 3 && uo_out[1] === 1'b1) && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (cycles == 3) uio_in[0] = 1'b0;
            if (retrig_at > 0 && cycles == retrig_at) uio_in[0] = 1'b1;
            if (retrig_at > 0 && cycles == retrig_at + 3) uio_in[0] = 1'b0;
            if (pause_at > 0 && cycles == pause_at) ena = 1'b0;
            if (pause_at > 0 && cycles == pause_at + Pause) ena = 1'b1;
            if (cycles == 5) begin
                checks++;
                if (uo_out[1:0] !== 2'b01) begin
                    failures++;
                    $display("FAIL %s_busy: uo_out[1:0]=%b required 01", name, uo_out[1:0]);
                end
            end
        end
        ena = 1'b1;
        uio_in[0] = 1'b0;
        exp_b = exp_q.pop_front();
        exp_l = lat_q.pop_front();
        checks++;
        if (cycles !== exp_l) begin
            failures++;
            $display("FAIL %s_latency: cycles=%0d required %0d", name, cycles, exp_l);
        end
        checks++;
        if (uo_out !== exp_b) begin
            failures++;
            $display("FAIL %s_result: uo_out=%b required %b", name, uo_out, exp_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out !== exp_b) begin
            failures++;
            $display("FAIL %s_hold: uo_out=%b required %b", name, uo_out, exp_b);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        uio_in = 8'h00;
        mode   = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uo_out: got %h required 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_uio_out: got %h required 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h03) begin
            failures++;
            $display("FAIL reset_uio_oe: got %h required 03", uio_oe);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (uo_out !== 8'h00) begin
            failures++;
            $display("FAIL idle_uo_out: got %h required 00", uo_out);
        end
    endtask

    task automatic test_reset_midrun();
        int  cycles;
        bit  any_busy;
        mode = 0;
        @(negedge clk);
        uio_in[0] = 1'b1;
        cycles = 0;
        while (uio_out[1:0] !== 2'b01 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles >= 100) begin
            failures++;
            $display("FAIL midrun_reach_vec2: timeout, uio_out=%h required 01", uio_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            failures++;
            $display("FAIL midrun_reset_outputs: uo_out=%h uio_out=%h required 00 00",
                     uo_out, uio_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        any_busy = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b0) any_busy = 1'b1;
        end
        checks++;
        if (any_busy) begin
            failures++;
            $display("FAIL held_start_no_run: busy seen=1 required 0");
        end
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        run_check("after_reset", 0, 0, 0);
    endtask

    initial begin
        test_reset();
        run_check("ideal", 0, 0, 0);
        run_check("xor_stuck0", 1, 0, 0);
        run_check("all_zero", 2, 0, 0);
        run_check("ena_pause", 0, 4, 0);
        run_check("back_to_back", 1, 0, 8);
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
